// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, round constants, state layout and FSM encoding.
// The state is column-major over the 128-bit bus: byte k sits at row k%4, column k/4.
package aes_pkg;

   typedef logic [0:3][0:3][7:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // Out-of-table indices yield 0 so idle-state decode never reads past the table.
   function automatic logic [7:0] rcon_of(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      if (i >= 4'd1 && i <= 4'd10) r = RCON[i];
      return r;
   endfunction

   function automatic state_t unpack(input logic [127:0] bus);
      state_t s;
      s = '0;
      for (int unsigned k = 0; k < 16; k++) s[k % 4][k / 4] = bus[127 - 8 * k -: 8];
      return s;
   endfunction

   function automatic logic [127:0] pack(input state_t s);
      logic [127:0] bus;
      bus = '0;
      for (int unsigned k = 0; k < 16; k++) bus[127 - 8 * k -: 8] = s[k % 4][k / 4];
      return bus;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-expansion step: four new schedule words from the previous four and the last word.
// rot_en selects RotWord+SubWord (with rcon) versus SubWord alone.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] prev4,
   input  logic [31:0]  last_word,
   input  logic         rot_en,
   input  logic [7:0]   rcon,
   output logic [127:0] next4
);

   logic [31:0] rot;
   logic [31:0] temp;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      rot  = rot_en ? {last_word[23:0], last_word[31:24]} : last_word;
      temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h000000};
      n0   = prev4[127:96] ^ temp;
      n1   = prev4[95:64]  ^ n0;
      n2   = prev4[63:32]  ^ n1;
      n3   = prev4[31:0]   ^ n2;
      next4 = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per clock with on-the-fly key expansion.
// Valid/ready on both sides; a new block may be accepted on the same edge the old one leaves.
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_block,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_block,
   output logic                busy
);

   localparam int NR = (KEY_BITS == 256) ? 14 : 10;

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_iter_core: KEY_BITS must be 128 or 256");
      end
   endgenerate

   fsm_t                fsm;
   logic [3:0]          round;
   state_t              state;
   logic [KEY_BITS-1:0] key_win;
   logic [KEY_BITS-1:0] key_adv;

   logic [127:0] prev4;
   logic [127:0] next4;
   logic [127:0] round_key;
   logic [31:0]  last_word;
   logic         rot_en;
   logic [7:0]   rc;

   state_t sb, sr, mc, round_out;
   logic   accept;
   logic   last_round;

   function automatic state_t sub_bytes(input state_t s);
      state_t o;
      o = '0;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++) o[r][c] = sbox(s[r][c]);
      return o;
   endfunction

   function automatic state_t shift_rows(input state_t s);
      state_t o;
      o = '0;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++) o[r][c] = s[r][(c + r) % 4];
      return o;
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         o[0][c] = gmul2(s[0][c]) ^ gmul3(s[1][c]) ^ s[2][c] ^ s[3][c];
         o[1][c] = s[0][c] ^ gmul2(s[1][c]) ^ gmul3(s[2][c]) ^ s[3][c];
         o[2][c] = s[0][c] ^ s[1][c] ^ gmul2(s[2][c]) ^ gmul3(s[3][c]);
         o[3][c] = gmul3(s[0][c]) ^ s[1][c] ^ s[2][c] ^ gmul2(s[3][c]);
      end
      return o;
   endfunction

   // The AES-256 window is {older four words, newer four words}; round 1 uses the newer half as-is.
   generate
      if (KEY_BITS == 256) begin : g_key256
         assign prev4     = key_win[255:128];
         assign last_word = key_win[31:0];
         assign rot_en    = ~round[0];
         assign rc        = round[0] ? 8'h00 : rcon_of({1'b0, round[3:1]});
         assign round_key = (round == 4'd1) ? key_win[127:0] : next4;
         assign key_adv   = (round == 4'd1) ? key_win : {key_win[127:0], next4};
      end else begin : g_key128
         assign prev4     = key_win[127:0];
         assign last_word = key_win[31:0];
         assign rot_en    = 1'b1;
         assign rc        = rcon_of(round);
         assign round_key = next4;
         assign key_adv   = next4;
      end
   endgenerate

   aes_key_step u_key_step (
      .prev4     (prev4),
      .last_word (last_word),
      .rot_en    (rot_en),
      .rcon      (rc),
      .next4     (next4)
   );

   assign last_round = (round == 4'(NR));

   always_comb begin
      sb        = sub_bytes(state);
      sr        = shift_rows(sb);
      mc        = mix_columns(sr);
      round_out = (last_round ? sr : mc) ^ unpack(round_key);
   end

   assign out_valid = (fsm == DONE);
   assign busy      = (fsm != IDLE);
   assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         round     <= '0;
         state     <= '0;
         key_win   <= '0;
         out_block <= '0;
      end else if (accept) begin
         state   <= unpack(in_block ^ in_key[KEY_BITS-1 -: 128]);
         key_win <= in_key;
         round   <= 4'd1;
         fsm     <= RUN;
      end else begin
         case (fsm)
            RUN: begin
               state   <= round_out;
               key_win <= key_adv;
               round   <= round + 4'd1;
               if (last_round) begin
                  out_block <= pack(round_out);
                  fsm       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) fsm <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors on a 128-bit and a 256-bit instance,
// plus backpressure, simultaneous handshakes, mid-run reset and input churn.
`timescale 1ns/1ps
module tb_aes_iter_core;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [127:0] a_in_block, a_in_key, a_out_block;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [127:0] b_in_block, b_out_block;
   logic [255:0] b_in_key;

   int checks = 0;
   int errors = 0;

   aes_iter_core #(.KEY_BITS(128)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_block  (a_in_block),
      .in_key    (a_in_key),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_block (a_out_block),
      .busy      (a_busy)
   );

   aes_iter_core #(.KEY_BITS(256)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_block  (b_in_block),
      .in_key    (b_in_key),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_block (b_out_block),
      .busy      (b_busy)
   );

   task automatic start_a(input logic [127:0] blk, input logic [127:0] key);
      int n;
      n = 0;
      a_in_block = blk;
      a_in_key   = key;
      a_in_valid = 1'b1;
      while (!a_in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic wait_a(output int cycles);
      cycles = 0;
      while (!a_out_valid && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_block = '0; a_in_key = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_block = '0; b_in_key = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid: got %b want 0", a_out_valid); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
      checks++; if (a_out_block !== 128'h0) begin errors++; $display("FAIL rst_a_out_block: got %h want 0", a_out_block); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid: got %b want 0", b_out_valid); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_in_ready: got %b want 1", a_in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b want 1", b_in_ready); end
   endtask

   task automatic test_fips_b();
      int cyc;
      start_a(PT_B, KEY_B);
      checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
         errors++; $display("FAIL b_run_flags: got busy=%b in_ready=%b out_valid=%b want 1 0 0", a_busy, a_in_ready, a_out_valid);
      end
      wait_a(cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL b_latency: got %0d want 10", cyc); end
      checks++; if (a_out_block !== CT_B) begin errors++; $display("FAIL b_ct: got %h want %h", a_out_block, CT_B); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL b_done_busy: got %b want 1", a_busy); end
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL b_drain: got out_valid=%b busy=%b want 0 0", a_out_valid, a_busy);
      end
   endtask

   task automatic test_fips_c1();
      int cyc;
      start_a(PT_C, KEY_C1);
      wait_a(cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL c1_latency: got %0d want 10", cyc); end
      checks++; if (a_out_block !== CT_C1) begin errors++; $display("FAIL c1_ct: got %h want %h", a_out_block, CT_C1); end
      @(posedge clk); #1;
   endtask

   task automatic test_aes256();
      int cyc;
      b_in_block = PT_C;
      b_in_key   = KEY_C3;
      b_in_valid = 1'b1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL c3_in_ready: got %b want 1", b_in_ready); end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL c3_busy: got %b want 1", b_busy); end
      cyc = 0;
      while (!b_out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc !== 14) begin errors++; $display("FAIL c3_latency: got %0d want 14", cyc); end
      checks++; if (b_out_block !== CT_C3) begin errors++; $display("FAIL c3_ct: got %h want %h", b_out_block, CT_C3); end
      @(posedge clk); #1;
      checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
         errors++; $display("FAIL c3_drain: got out_valid=%b busy=%b want 0 0", b_out_valid, b_busy);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      a_out_ready = 1'b0;
      start_a(PT_B, KEY_B);
      wait_a(cyc);
      checks++; if (cyc !== 10 || a_out_block !== CT_B) begin
         errors++; $display("FAIL bp_first: got cyc=%0d ct=%h want 10 %h", cyc, a_out_block, CT_B);
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         checks++; if (a_out_valid !== 1'b1 || a_out_block !== CT_B || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b ct=%h want 1 0 %h", i, a_out_valid, a_in_ready, a_out_block, CT_B);
         end
      end
      a_in_block  = PT_C;
      a_in_key    = KEY_C1;
      a_in_valid  = 1'b1;
      a_out_ready = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
         errors++; $display("FAIL bp_swap: got out_valid=%b busy=%b want 0 1", a_out_valid, a_busy);
      end
      wait_a(cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL bp_second_latency: got %0d want 10", cyc); end
      checks++; if (a_out_block !== CT_C1) begin errors++; $display("FAIL bp_second_ct: got %h want %h", a_out_block, CT_C1); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun();
      int cyc;
      start_a(PT_C, KEY_C1);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL mid_rst_flags: got out_valid=%b busy=%b want 0 0", a_out_valid, a_busy);
      end
      checks++; if (a_out_block !== 128'h0) begin errors++; $display("FAIL mid_rst_out_block: got %h want 0", a_out_block); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_rst_idle: got in_ready=%b out_valid=%b want 1 0", a_in_ready, a_out_valid);
      end
      start_a(PT_B, KEY_B);
      wait_a(cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL mid_rst_latency: got %0d want 10", cyc); end
      checks++; if (a_out_block !== CT_B) begin errors++; $display("FAIL mid_rst_ct: got %h want %h", a_out_block, CT_B); end
      @(posedge clk); #1;
   endtask

   task automatic test_input_churn();
      int cyc;
      start_a(PT_C, KEY_C1);
      cyc = 0;
      while (!a_out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         a_in_block = {$urandom, $urandom, $urandom, $urandom};
         a_in_key   = {$urandom, $urandom, $urandom, $urandom};
         a_in_valid = (cyc < 8);
      end
      a_in_valid = 1'b0;
      checks++; if (cyc !== 10) begin errors++; $display("FAIL churn_latency: got %0d want 10", cyc); end
      checks++; if (a_out_block !== CT_C1) begin errors++; $display("FAIL churn_ct: got %h want %h", a_out_block, CT_C1); end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_aes256();
      test_back_to_back();
      test_reset_midrun();
      test_input_churn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
